// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the exhaustive 4-input logic sweep controller.
package logic_sweep_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 4;
    localparam int FAIL_W      = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Down-counter that gives the logic block under sweep time to settle on each vector.
module sweep_settle_timer
    import logic_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Expiry is flagged on the last settle cycle so the FSM leaves DRIVE on time.
    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps all 16 input vectors of a 4-input logic block and compares against a golden table.
// Optional SWEEP_STOP_ON_FAIL_EN: end the sweep on the first mismatching vector.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    input  logic                   dut_o,
    output logic [IDX_W-1:0]       dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] captured,
    output logic [FAIL_W-1:0]      fail_count,
    output logic [IDX_W-1:0]       first_fail_idx,
    output logic [1:0]             dbg_state
);

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(NUM_VECTORS);

    sweep_state_t           state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_VECTORS-1:0] exp_latched;

    logic                   accept;
    logic                   mismatch;
    logic                   stop;
    logic [FAIL_W-1:0]      fail_next;
    logic                   timer_load;
    logic                   expire;

    // Handshake: start is a request sampled only while busy=0 (IDLE or DONE);
    // while busy=1 it is ignored, so no ready signal is needed.
    assign accept    = (state == IDLE || state == DONE) && start;
    assign mismatch  = (dut_o != exp_latched[idx]);
    assign fail_next = (mismatch && fail_count < FAIL_MAX) ? fail_count + 1'b1 : fail_count;

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop = (idx == LAST_IDX) || mismatch;
`else
    assign stop = (idx == LAST_IDX);
`endif

    assign timer_load = accept || (state == SAMPLE && !stop);

    sweep_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .tick     (state == DRIVE),
        .expire   (expire)
    );

    assign dut_in    = idx;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            exp_latched    <= '0;
            captured       <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        exp_latched    <= expected;
                        captured       <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        idx            <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        state          <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    captured[idx] <= dut_o;
                    fail_count    <= fail_next;
                    if (mismatch && fail_count == '0) begin
                        first_fail_idx <= idx;
                    end
                    if (stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_next == '0);
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Self-checking bench: two controllers (settle 1 and 3) sweep the same truth table side by side.
module tb_logic_sweep_ctrl;

    localparam int S_A = 1;
    localparam int S_B = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic [15:0] dut_tt;

    logic        a_dut_o, b_dut_o;
    logic [3:0]  a_dut_in, b_dut_in;
    logic        a_busy, b_busy, a_done, b_done, a_pass, b_pass;
    logic [15:0] a_captured, b_captured;
    logic [4:0]  a_fail_count, b_fail_count;
    logic [3:0]  a_first_fail_idx, b_first_fail_idx;
    logic [1:0]  a_dbg_state, b_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // The logic block under sweep is modelled as its own truth table.
    assign a_dut_o = dut_tt[a_dut_in];
    assign b_dut_o = dut_tt[b_dut_in];

    logic_sweep_ctrl #(.SETTLE_CYCLES(S_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_o(a_dut_o),
        .dut_in(a_dut_in), .busy(a_busy), .done(a_done), .pass(a_pass),
        .captured(a_captured), .fail_count(a_fail_count),
        .first_fail_idx(a_first_fail_idx), .dbg_state(a_dbg_state)
    );

    logic_sweep_ctrl #(.SETTLE_CYCLES(S_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_o(b_dut_o),
        .dut_in(b_dut_in), .busy(b_busy), .done(b_done), .pass(b_pass),
        .captured(b_captured), .fail_count(b_fail_count),
        .first_fail_idx(b_first_fail_idx), .dbg_state(b_dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: result of sweeping truth table tt against golden ex with settle s.
    task automatic model_sweep(input logic [15:0] tt, input logic [15:0] ex, input int s,
                               output logic [15:0] cap, output int fails, output int ff,
                               output int lat, output int last);
        logic [15:0] mism;
        bit found;
        mism  = tt ^ ex;
        fails = 0;
        ff    = 0;
        found = 0;
        for (int i = 0; i < 16; i++) begin
            if (mism[i]) begin
                fails++;
                if (!found) begin
                    ff = i;
                    found = 1;
                end
            end
        end
        cap  = tt;
        last = 15;
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (found) begin
            fails = 1;
            last  = ff;
            cap   = tt & ((16'h1 << (ff + 1)) - 16'h1);
        end
`endif
        lat = (last + 1) * (s + 1);
    endtask

    function automatic int exp_idx(input int c, input int s, input int last);
        int v;
        v = c / (s + 1);
        return (v > last) ? last : v;
    endfunction

    task automatic run_sweep(input logic [15:0] tt, input logic [15:0] ex,
                             input bit restart, input string name);
        logic [15:0] cap_a, cap_b;
        int fails_a, fails_b, ff_a, ff_b, elat_a, elat_b, last_a, last_b;
        int lat_a, lat_b, bad_a, bad_b;

        model_sweep(tt, ex, S_A, cap_a, fails_a, ff_a, elat_a, last_a);
        model_sweep(tt, ex, S_B, cap_b, fails_b, ff_b, elat_b, last_b);
        dut_tt = tt;
        lat_a = -1;
        lat_b = -1;
        bad_a = 0;
        bad_b = 0;

        @(negedge clk);
        expected = ex;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        expected = 16'($urandom);

        for (int c = 0; c <= 300; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            start = restart && (c == 9);
            if (int'(a_dut_in) != exp_idx(c, S_A, last_a)) bad_a++;
            if (int'(b_dut_in) != exp_idx(c, S_B, last_b)) bad_b++;
            if (a_busy != (c < elat_a)) bad_a++;
            if (b_busy != (c < elat_b)) bad_b++;
            if (a_done && lat_a < 0) lat_a = c;
            if (b_done && lat_b < 0) lat_b = c;
            if (lat_a >= 0 && lat_b >= 0) break;
        end
        start = 1'b0;

        check_eq({name, "_lat_a"}, lat_a, elat_a);
        check_eq({name, "_lat_b"}, lat_b, elat_b);
        check_eq({name, "_trace_a"}, bad_a, 0);
        check_eq({name, "_trace_b"}, bad_b, 0);

        repeat (3) @(posedge clk);
        #1;
        check_eq({name, "_done_hold_a"}, a_done, 1);
        check_eq({name, "_done_hold_b"}, b_done, 1);
        check_eq({name, "_cap_a"}, a_captured, cap_a);
        check_eq({name, "_cap_b"}, b_captured, cap_b);
        check_eq({name, "_fails_a"}, a_fail_count, fails_a);
        check_eq({name, "_fails_b"}, b_fail_count, fails_b);
        check_eq({name, "_pass_a"}, a_pass, fails_a == 0);
        check_eq({name, "_pass_b"}, b_pass, fails_b == 0);
        check_eq({name, "_ffi_a"}, a_first_fail_idx, ff_a);
        check_eq({name, "_ffi_b"}, b_first_fail_idx, ff_b);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_ctl_a"},
                 {a_dut_in, a_busy, a_done, a_pass, a_fail_count, a_first_fail_idx, a_dbg_state}, 0);
        check_eq({name, "_ctl_b"},
                 {b_dut_in, b_busy, b_done, b_pass, b_fail_count, b_first_fail_idx, b_dbg_state}, 0);
        check_eq({name, "_cap_a"}, a_captured, 0);
        check_eq({name, "_cap_b"}, b_captured, 0);
    endtask

    task automatic check_idle_after_release(input string name);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq({name, "_idle_a"}, {a_busy, a_done, a_dbg_state}, 0);
        check_eq({name, "_idle_b"}, {b_busy, b_done, b_dbg_state}, 0);
    endtask

    task automatic reset_mid_sweep();
        bit found;
        found = 0;
        dut_tt = 16'hFFFF;
        @(negedge clk);
        expected = 16'hFFFF;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (a_dut_in == 4'd7) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq("mid_reach_idx7", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        check_idle_after_release("mid_release");
    endtask

    initial begin
        logic [15:0] tt, ex;
        rst_n    = 1'b0;
        start    = 1'b0;
        expected = 16'h0;
        dut_tt   = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_idle_after_release("release");

        run_sweep(16'h8000, 16'h8000, 1'b0, "and4_pass");
        run_sweep(16'h8000, 16'hFFFF, 1'b0, "and4_all1");
        run_sweep(16'h6996, 16'h6996, 1'b0, "xor4_pass");
        run_sweep(16'h8000, 16'h8000, 1'b1, "busy_start");

        for (int i = 0; i < 8; i++) begin
            tt = 16'($urandom);
            ex = tt;
            if ($urandom_range(0, 3) != 0) ex = ex ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0) ex = ex ^ (16'h1 << $urandom_range(0, 15));
            run_sweep(tt, ex, 1'b0, $sformatf("rand%0d", i));
        end

        reset_mid_sweep();
        run_sweep(16'h6996, 16'h0000, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
